// File: rtl/keypad_encoder.sv
// Keypad front-end for the timer digit counters: synchronises and debounces the
// 10-key pad, emits the BCD digit with a one-cycle load strobe, and divides clk into a count tick.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 100
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [9:0] keypad,
  input  logic       enablen,
  output logic [3:0] data,
  output logic       load,
  output logic       tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DIV_ONE  = TW'(1);
  localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DEB = 2'd1, HELD = 2'd2, REL = 2'd3} state_t;

  function automatic logic [9:0] onehot(input logic [3:0] code);
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = (code == 4'(i));
    return v;
  endfunction

  function automatic logic is_single(input logic [9:0] k);
    return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] encode(input logic [9:0] k);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 10; i++) c = k[i] ? 4'(i) : c;
    return c;
  endfunction

  state_t        state_r, state_nx_s;
  logic [9:0]    sync1_r, ks_r;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic [3:0]    cand_r, cand_nx_s, data_r, data_nx_s;
  logic          load_r, load_nx_s, tick_r;
  logic [TW-1:0] div_r;
  logic          single_s, cand_ok_s, cnt_last_s;

  assign single_s   = is_single(ks_r);
  assign cand_ok_s  = (ks_r == onehot(cand_r)) && !enablen;
  assign cnt_last_s = (cnt_r == CNT_LAST);

  // Two-flop synchroniser for the asynchronous keypad
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      sync1_r <= 10'd0;
      ks_r    <= 10'd0;
    end else begin
      sync1_r <= keypad;
      ks_r    <= sync1_r;
    end
  end

  // FSM state, debounce counter, candidate and registered outputs
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      cand_r  <= 4'd0;
      data_r  <= 4'd0;
      load_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      cand_r  <= cand_nx_s;
      data_r  <= data_nx_s;
      load_r  <= load_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: if (single_s && !enablen) state_nx_s = DEB; else state_nx_s = IDLE;
      DEB: begin
        if (!cand_ok_s)      state_nx_s = IDLE;
        else if (cnt_last_s) state_nx_s = HELD;
        else                 state_nx_s = DEB;
      end
      // Release is tracked regardless of enablen so a key held across unlock never fires
      HELD: if (ks_r == 10'd0) state_nx_s = REL; else state_nx_s = HELD;
      REL: begin
        if (ks_r != 10'd0)   state_nx_s = HELD;
        else if (cnt_last_s) state_nx_s = IDLE;
        else                 state_nx_s = REL;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Counter, candidate digit and load/data next values
  always_comb begin
    cnt_nx_s  = cnt_r;
    cand_nx_s = cand_r;
    data_nx_s = data_r;
    load_nx_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (single_s && !enablen) begin
          cand_nx_s = encode(ks_r);
          cnt_nx_s  = CNT_ONE;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      DEB: begin
        if (!cand_ok_s) begin
          cnt_nx_s = cnt_r;
        end else if (cnt_last_s) begin
          data_nx_s = cand_r;
          load_nx_s = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      HELD: if (ks_r == 10'd0) cnt_nx_s = CNT_ONE; else cnt_nx_s = cnt_r;
      REL: begin
        if (ks_r != 10'd0 || cnt_last_s) cnt_nx_s = cnt_r;
        else                             cnt_nx_s = cnt_r + CNT_ONE;
      end
      default: cnt_nx_s = '0;
    endcase
  end

  // Free-running tick divider; tick follows the wrap edge by one register stage
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      div_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      div_r  <= (div_r == DIV_LAST) ? '0 : div_r + DIV_ONE;
      tick_r <= (div_r == DIV_LAST);
    end
  end

  assign data = data_r;
  assign load = load_r;
  assign tick = tick_r;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed self-checking bench for keypad_encoder (DEBOUNCE_CYCLES=4, TICK_DIV=5).
module tb_keypad_encoder;

  logic       clk = 1'b0;
  logic       clearn;
  logic [9:0] keypad;
  logic       enablen;
  logic [3:0] data;
  logic       load;
  logic       tick;

  int checks = 0;
  int fails = 0;
  int load_count = 0;
  int load_en_count = 0;

  keypad_encoder #(.DEBOUNCE_CYCLES(4), .TICK_DIV(5)) dut (
    .clk(clk), .clearn(clearn), .keypad(keypad), .enablen(enablen),
    .data(data), .load(load), .tick(tick)
  );

  always #5 clk = ~clk;

  // Count load pulses, and any that appear while entry is locked
  always @(negedge clk) begin
    if (clearn && load) begin
      load_count++;
      if (enablen) load_en_count++;
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_keys();
    keypad = 10'd0;
    edges(12);
  endtask

  task automatic test_reset();
    clearn = 1'b0; keypad = 10'd0; enablen = 1'b0;
    #3;
    for (int i = 0; i < 8; i++) begin
      keypad  = 10'd1 << i;
      enablen = i[0];
      edges(1);
      checks++;
      if (data !== 4'd0 || load !== 1'b0 || tick !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: data=%0d load=%b tick=%b, required 0/0/0", i, data, load, tick);
      end
    end
    keypad = 10'd0; enablen = 1'b0;
    clearn = 1'b1;
  endtask

  task automatic test_tick(input string tag);
    int l0;
    l0 = load_count;
    for (int k = 1; k <= 12; k++) begin
      keypad = (k % 2 == 1) ? 10'b00_0000_0011 : 10'd0;
      edges(1);
      checks++;
      if (tick !== (k % 5 == 0)) begin
        fails++;
        $display("FAIL %s edge %0d: tick=%b, required %b", tag, k, tick, (k % 5 == 0));
      end
    end
    keypad = 10'd0;
    checks++;
    if (load_count - l0 !== 0) begin
      fails++;
      $display("FAIL %s loads: %0d, required 0", tag, load_count - l0);
    end
    edges(4);
  endtask

  task automatic test_single_press();
    int l0;
    l0 = load_count;
    enablen = 1'b0;
    keypad = 10'd1 << 7;
    edges(5);
    checks++;
    if (load !== 1'b0) begin
      fails++; $display("FAIL press_early: load=%b after E5, required 0", load);
    end
    edges(1);
    checks++;
    if (load !== 1'b1 || data !== 4'd7) begin
      fails++; $display("FAIL press_e6: load=%b data=%0d, required 1/7", load, data);
    end
    edges(1);
    checks++;
    if (load !== 1'b0) begin
      fails++; $display("FAIL press_pulse: load=%b after E7, required 0", load);
    end
    edges(62);
    checks++;
    if (load_count - l0 !== 1 || data !== 4'd7) begin
      fails++; $display("FAIL press_hold: loads=%0d data=%0d, required 1/7", load_count - l0, data);
    end
    release_keys();
  endtask

  task automatic test_bounce();
    int l0;
    l0 = load_count;
    for (int i = 0; i < 18; i++) begin
      keypad = (i % 3 == 2) ? 10'd0 : (10'd1 << 3);
      edges(1);
    end
    checks++;
    if (load_count - l0 !== 0 || data !== 4'd7) begin
      fails++; $display("FAIL bounce: loads=%0d data=%0d, required 0/7", load_count - l0, data);
    end
    keypad = 10'd1 << 3;
    edges(10);
    checks++;
    if (load_count - l0 !== 1 || data !== 4'd3) begin
      fails++; $display("FAIL bounce_stable: loads=%0d data=%0d, required 1/3", load_count - l0, data);
    end
    release_keys();
  endtask

  task automatic test_multi_key();
    int l0;
    l0 = load_count;
    keypad = (10'd1 << 2) | (10'd1 << 5);
    edges(20);
    checks++;
    if (load_count - l0 !== 0 || data !== 4'd3) begin
      fails++; $display("FAIL multi: loads=%0d data=%0d, required 0/3", load_count - l0, data);
    end
    release_keys();
    keypad = 10'd1 << 5;
    edges(10);
    checks++;
    if (load_count - l0 !== 1 || data !== 4'd5) begin
      fails++; $display("FAIL multi_then_5: loads=%0d data=%0d, required 1/5", load_count - l0, data);
    end
    release_keys();
  endtask

  task automatic test_enable_lockout();
    int l0;
    l0 = load_count;
    enablen = 1'b1;
    keypad = 10'd1 << 4;
    edges(15);
    checks++;
    if (load_count - l0 !== 0 || data !== 4'd5) begin
      fails++; $display("FAIL locked: loads=%0d data=%0d, required 0/5", load_count - l0, data);
    end
    release_keys();
    enablen = 1'b0;
    keypad = 10'd1 << 1;
    edges(4);
    enablen = 1'b1;
    edges(10);
    checks++;
    if (load_count - l0 !== 0 || data !== 4'd5) begin
      fails++; $display("FAIL abort_deb: loads=%0d data=%0d, required 0/5", load_count - l0, data);
    end
    release_keys();
    enablen = 1'b0;
    edges(2);
    checks++;
    if (load_en_count !== 0) begin
      fails++; $display("FAIL load_while_locked: %0d pulses, required 0", load_en_count);
    end
  endtask

  task automatic test_reset_mid_press();
    keypad = 10'd1 << 6;
    edges(4);
    #3;
    clearn = 1'b0;
    #1;
    checks++;
    if (data !== 4'd0 || load !== 1'b0 || tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: data=%0d load=%b tick=%b, required 0/0/0", data, load, tick);
    end
    keypad = 10'd0;
    @(posedge clk);
    #1;
    clearn = 1'b1;
    test_tick("tick_restart");
  endtask

  initial begin
    test_reset();
    test_tick("tick");
    test_single_press();
    test_bounce();
    test_multi_key();
    test_enable_lockout();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
